// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encoding, default
// timing parameters and the next-state rule used by the FSM and the buzzer gate.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarmStateT;

  localparam int RING_MINUTES_DEFAULT   = 5;
  localparam int SNOOZE_MINUTES_DEFAULT = 9;
  localparam int TONE_HALF_DEFAULT      = 50000;
  localparam int BEAT_CYCLES_DEFAULT    = 25000000;

  // Button inputs are one-cycle pulses; there is no handshake, a pulse is
  // acted on in the cycle it is high and never held or queued.
  // Priority: dismiss > armToggle > snooze > minTick/matchRise.
  function automatic alarmStateT nextState(
    input alarmStateT cur,
    input logic       matchRise,
    input logic       armToggle,
    input logic       snooze,
    input logic       dismiss,
    input logic       minTick,
    input logic [5:0] ringCnt,
    input logic [5:0] snoozeCnt,
    input logic [5:0] ringLimit,
    input logic [5:0] snoozeLimit
  );
    alarmStateT nxt;
    nxt = cur;
    case (cur)
      IDLE: begin
        if (armToggle) nxt = ARMED;
      end
      ARMED: begin
        if (armToggle)      nxt = IDLE;
        else if (matchRise) nxt = RINGING;
      end
      RINGING: begin
        if (dismiss)        nxt = ARMED;
        else if (armToggle) nxt = IDLE;
        else if (snooze)    nxt = SNOOZE;
        else if (minTick && ((ringCnt + 6'd1) == ringLimit)) nxt = ARMED;
      end
      SNOOZE: begin
        if (dismiss)        nxt = ARMED;
        else if (armToggle) nxt = IDLE;
        else if (minTick && ((snoozeCnt + 6'd1) == snoozeLimit)) nxt = RINGING;
      end
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Buzzer waveform: a tone square wave gated on/off by a slower beat.
// clear restarts the pattern (tone low, beat on); en lets it run.
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE_HALF   = TONE_HALF_DEFAULT,
  parameter int BEAT_CYCLES = BEAT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic buzzer
);

  localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);

  logic [TONE_W-1:0] toneCnt;
  logic [BEAT_W-1:0] beatCnt;
  logic              tone;
  logic              beatOn;
  logic              toneWrap;
  logic              beatWrap;
  logic              toneNext;
  logic              beatNext;

  assign toneWrap = (toneCnt == TONE_LAST);
  assign beatWrap = (beatCnt == BEAT_LAST);
  assign toneNext = toneWrap ? ~tone : tone;
  assign beatNext = beatWrap ? ~beatOn : beatOn;

  // Counters advance only while enabled; buzzer follows the updated tone/beat
  // so the first high half-period appears without an extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      toneCnt <= '0;
      beatCnt <= '0;
      tone    <= 1'b0;
      beatOn  <= 1'b1;
      buzzer  <= 1'b0;
    end else if (en) begin
      toneCnt <= toneWrap ? '0 : toneCnt + 1'b1;
      beatCnt <= beatWrap ? '0 : beatCnt + 1'b1;
      tone    <= toneNext;
      beatOn  <= beatNext;
      buzzer  <= toneNext & beatNext;
    end else begin
      buzzer  <= 1'b0;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: detects the rising edge of time==alarm, runs the
// IDLE/ARMED/RINGING/SNOOZE state machine and drives the buzzer.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_MINUTES   = RING_MINUTES_DEFAULT,
  parameter int SNOOZE_MINUTES = SNOOZE_MINUTES_DEFAULT,
  parameter int TONE_HALF      = TONE_HALF_DEFAULT,
  parameter int BEAT_CYCLES    = BEAT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] time_hour,
  input  logic [5:0] time_min,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       min_tick,
  input  logic       arm_toggle,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzzer,
  output logic [1:0] state,
  output logic       ringing,
  output logic       armed_led
);

  alarmStateT stateQ;
  alarmStateT stateNext;
  logic       match;
  logic       matchQ;
  logic       matchRise;
  logic [5:0] ringCnt;
  logic [5:0] snoozeCnt;
  logic       toneClear;
  logic       toneEn;

  // Out-of-range times are simply compared; equality alone decides.
  assign match     = (time_hour == alarm_hour) && (time_min == alarm_min);
  assign matchRise = match & ~matchQ;

  assign stateNext = nextState(stateQ, matchRise, arm_toggle, snooze, dismiss,
                               min_tick, ringCnt, snoozeCnt,
                               6'(RING_MINUTES), 6'(SNOOZE_MINUTES));

  // Tone pattern is held cleared outside RINGING so every entry starts fresh,
  // and is disabled on the edge that leaves RINGING so the buzzer drops at once.
  assign toneClear = (stateQ != RINGING);
  assign toneEn    = (stateNext == RINGING);
  assign state     = stateQ;

  // State register, match history, minute counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= IDLE;
      matchQ    <= 1'b0;
      ringCnt   <= '0;
      snoozeCnt <= '0;
      ringing   <= 1'b0;
      armed_led <= 1'b0;
    end else begin
      matchQ    <= match;
      stateQ    <= stateNext;
      ringing   <= (stateNext == RINGING);
      armed_led <= (stateNext != IDLE);
      if ((stateNext == RINGING) && (stateQ != RINGING)) begin
        ringCnt <= '0;
      end else if ((stateQ == RINGING) && min_tick && !dismiss && !arm_toggle && !snooze) begin
        ringCnt <= ringCnt + 6'd1;
      end
      if ((stateNext == SNOOZE) && (stateQ != SNOOZE)) begin
        snoozeCnt <= '0;
      end else if ((stateQ == SNOOZE) && min_tick && !dismiss && !arm_toggle) begin
        snoozeCnt <= snoozeCnt + 6'd1;
      end
    end
  end

  alarm_tone_gen #(
    .TONE_HALF   (TONE_HALF),
    .BEAT_CYCLES (BEAT_CYCLES)
  ) toneGen (
    .clk    (clk),
    .rst    (rst),
    .clear  (toneClear),
    .en     (toneEn),
    .buzzer (buzzer)
  );

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short tone/beat/minute parameters.
module tb_alarm_ctrl;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_RINGING = 2'd2;
  localparam logic [1:0] S_SNOOZE  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] timeHour = 5'd7;
  logic [5:0] timeMin = 6'd29;
  logic [4:0] alarmHour = 5'd7;
  logic [5:0] alarmMin = 6'd30;
  logic       minTick = 1'b0;
  logic       armToggle = 1'b0;
  logic       snoozeBtn = 1'b0;
  logic       dismissBtn = 1'b0;
  logic       buzzer;
  logic [1:0] state;
  logic       ringing;
  logic       armedLed;

  int nChecks = 0;
  int nErrors = 0;
  logic [0:0] expQ[$];

  alarm_ctrl #(
    .RING_MINUTES   (3),
    .SNOOZE_MINUTES (2),
    .TONE_HALF      (2),
    .BEAT_CYCLES    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .time_hour  (timeHour),
    .time_min   (timeMin),
    .alarm_hour (alarmHour),
    .alarm_min  (alarmMin),
    .min_tick   (minTick),
    .arm_toggle (armToggle),
    .snooze     (snoozeBtn),
    .dismiss    (dismissBtn),
    .buzzer     (buzzer),
    .state      (state),
    .ringing    (ringing),
    .armed_led  (armedLed)
  );

  // clock
  always #5 clk = ~clk;

  // one active edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic setTime(input logic [5:0] m);
    timeMin = m;
    step();
  endtask

  task automatic pulseArm();
    armToggle = 1'b1; step(); armToggle = 1'b0;
  endtask

  task automatic pulseTick();
    minTick = 1'b1; step(); minTick = 1'b0;
  endtask

  initial begin
    bit seen;

    // reset
    step(); step();
    checkVal("rst_state", state, S_IDLE);
    checkVal("rst_buzzer", buzzer, 0);
    checkVal("rst_ringing", ringing, 0);
    checkVal("rst_led", armedLed, 0);
    rst = 1'b0;
    step();

    // dismiss ignored in IDLE
    dismissBtn = 1'b1; step(); dismissBtn = 1'b0;
    checkVal("idle_dismiss", state, S_IDLE);

    // arm, then time 07:29 -> 07:30 rings one cycle later
    pulseArm();
    checkVal("arm_state", state, S_ARMED);
    checkVal("arm_led", armedLed, 1);
    step();
    setTime(6'd30);
    checkVal("ring_state", state, S_RINGING);
    checkVal("ring_flag", ringing, 1);
    expQ = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      checkVal($sformatf("buzz_%0d", i), buzzer, expQ.pop_front());
      step();
    end

    // three minute ticks with no buttons -> back to ARMED, silent
    pulseTick();
    checkVal("tick1_state", state, S_RINGING);
    pulseTick();
    checkVal("tick2_state", state, S_RINGING);
    pulseTick();
    checkVal("tick3_state", state, S_ARMED);
    checkVal("tick3_buzzer", buzzer, 0);
    checkVal("tick3_ringing", ringing, 0);
    step(); step(); step();
    checkVal("no_retrigger", state, S_ARMED);

    // re-ring, snooze for two ticks, then dismiss beats arm_toggle
    setTime(6'd31);
    setTime(6'd30);
    checkVal("ring2_state", state, S_RINGING);
    snoozeBtn = 1'b1; step(); snoozeBtn = 1'b0;
    checkVal("snooze_state", state, S_SNOOZE);
    checkVal("snooze_buzzer", buzzer, 0);
    pulseTick();
    checkVal("snz_tick1", state, S_SNOOZE);
    pulseTick();
    checkVal("snz_tick2", state, S_RINGING);
    checkVal("snz_buzz0", buzzer, 0);
    step();
    checkVal("snz_buzz1", buzzer, 0);
    step();
    checkVal("snz_buzz2", buzzer, 1);
    dismissBtn = 1'b1; armToggle = 1'b1; step();
    dismissBtn = 1'b0; armToggle = 1'b0;
    checkVal("dis_arm_prio", state, S_ARMED);
    checkVal("dis_buzzer", buzzer, 0);

    // arming while the time already matches does not ring
    pulseArm();
    checkVal("disarm", state, S_IDLE);
    pulseArm();
    step(); step(); step();
    checkVal("arm_on_match", state, S_ARMED);
    setTime(6'd31);
    checkVal("leave_match", state, S_ARMED);
    setTime(6'd30);
    checkVal("return_match", ringing, 1);

    // reset while buzzer is high
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (buzzer === 1'b1) seen = 1'b1;
      else step();
    end
    checkVal("buzz_high_seen", {31'd0, seen}, 1);
    rst = 1'b1; step();
    checkVal("midring_rst_state", state, S_IDLE);
    checkVal("midring_rst_buzzer", buzzer, 0);
    checkVal("midring_rst_led", armedLed, 0);
    rst = 1'b0;
    step();

    // arm_toggle outranks snooze in RINGING
    pulseArm();
    setTime(6'd31);
    setTime(6'd30);
    checkVal("ring3_state", state, S_RINGING);
    snoozeBtn = 1'b1; armToggle = 1'b1; step();
    snoozeBtn = 1'b0; armToggle = 1'b0;
    checkVal("arm_snz_prio", state, S_IDLE);

    // reset outranks arm_toggle
    rst = 1'b1; armToggle = 1'b1; step();
    rst = 1'b0; armToggle = 1'b0;
    checkVal("rst_prio", state, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_MINUTES, default 5, minute ticks before an unanswered ring auto-stops (1..63).
REQ-002 SHALL have parameter SNOOZE_MINUTES, default 9, minute ticks of snooze before re-ring (1..63).
REQ-003 SHALL have parameter TONE_HALF, default 50000, clk cycles per buzzer half-period (1 kHz at 100 MHz).
REQ-004 SHALL have parameter BEAT_CYCLES, default 25000000, clk cycles per beep on/off phase.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports time_hour/time_min  input  5/6  current clock time, binary, hour 0..23, min 0..59.
REQ-008 SHALL have ports alarm_hour/alarm_min  input  5/6  alarm setpoint, same encoding.
REQ-009 SHALL have port min_tick  input  1  one-cycle pulse on each minute rollover.
REQ-010 SHALL have ports arm_toggle, snooze, dismiss  input  1 each  one-cycle debounced button pulses.
REQ-011 SHALL have port buzzer  output  1  gated square-wave drive.
REQ-012 SHALL have ports state  output  2  current FSM state; ringing  output  1  high iff state==RINGING; armed_led  output  1  high iff state!=IDLE.

Function
REQ-013 SHALL implement states IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-014 SHALL compute match = (time_hour==alarm_hour)&&(time_min==alarm_min), register it as match_q, and define match_rise = match & ~match_q.
REQ-015 SHALL update match_q every cycle in every state, so a match already present on arming does not trigger.
REQ-016 IDLE: arm_toggle -> ARMED; all else ignored.
REQ-017 ARMED: arm_toggle -> IDLE; else match_rise -> RINGING, ring minute counter cleared; ringing high the cycle after match first appears on inputs.
REQ-018 RINGING: dismiss -> ARMED; else arm_toggle -> IDLE; else snooze -> SNOOZE, snooze counter cleared; else min_tick increments ring counter and the tick making it equal RING_MINUTES -> ARMED.
REQ-019 SNOOZE: dismiss -> ARMED; else arm_toggle -> IDLE; else min_tick increments snooze counter and the tick making it equal SNOOZE_MINUTES -> RINGING, ring counter cleared.
REQ-020 Priority on simultaneous inputs SHALL be dismiss > arm_toggle > snooze > min_tick/match_rise; snooze in any state but RINGING, and dismiss in IDLE/ARMED, are ignored.
REQ-021 Minute counters SHALL be 6 bits, saturate never needed (cleared on entry), and hold value outside their owning state.
REQ-022 Tone counter SHALL count 0..TONE_HALF-1 and wrap, toggling tone bit on wrap; beat counter counts 0..BEAT_CYCLES-1 and wraps, toggling beat_on on wrap.
REQ-023 On every entry to RINGING, tone counter, beat counter and tone bit SHALL clear to 0 and beat_on set to 1; counters run only in RINGING.
REQ-024 buzzer SHALL be registered and equal tone & beat_on while RINGING, 0 in all other states, including the cycle the FSM leaves RINGING.
REQ-025 time inputs out of range SHALL only be compared, never flagged; equality alone decides match.

Reset
REQ-026 rst SHALL set state=IDLE, match_q=0, all counters 0, tone=0, beat_on=1, buzzer=0, ringing=0, armed_led=0; rst mid-ring silences buzzer next cycle.
REQ-027 rst SHALL take priority over every input in the same cycle.

Structure
REQ-028 State encodings and default parameter values SHALL live in shared package alarm_pkg.
REQ-029 Tone/beat generation SHALL be one sub-module alarm_tone_gen (inputs clk, rst, clear, en; output buzzer); FSM and comparison stay in alarm_ctrl.

Verification (TONE_HALF=2, BEAT_CYCLES=8, RING_MINUTES=3, SNOOZE_MINUTES=2)
REQ-030 Arm, alarm 07:30, time steps 07:29->07:30 -> ringing=1 one cycle later; buzzer pattern 0,0,1,1,0,0,1,1 then 8 cycles 0.
REQ-031 Ringing, 3 min_tick pulses, no buttons -> state ARMED after 3rd tick, buzzer 0; time held 07:30 -> no re-trigger.
REQ-032 Ringing, snooze, 2 min_tick -> SNOOZE then RINGING on 2nd tick; then dismiss+arm_toggle same cycle -> ARMED.
REQ-033 Time already 07:30 when arm_toggle pulses -> stays ARMED, no ring until time leaves and returns to 07:30.
REQ-034 rst asserted mid-RINGING with buzzer=1 -> next cycle state=0, buzzer=0, armed_led=0.
